// File: rtl/geofence_pkg.sv
// Shared geofence types: coordinate width, point and cross-product operand
// structs, and the request-to-response latency of the shared evaluator.
package geofence_pkg;

    localparam int CW        = 10;
    localparam int CROSS_LAT = 3;

    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    // Field order matches the {Px,Py,Qx,Qy,Ax,Ay,Bx,By} operand bus, MSB first.
    typedef struct packed {
        point_t p;
        point_t q;
        point_t a;
        point_t b;
    } cross_op_t;

endpackage

// File: rtl/cross_core.sv
// Two-stage cross-product sign unit: products registered in S1, sign in S2.
// With CROSS_ZERO_EN defined it also flags collinear operands on o_zero.
module cross_core
    import geofence_pkg::*;
(
    input  logic      clk,
    input  logic      i_reset,
    input  cross_op_t i_op,
    output logic      o_pos
`ifdef CROSS_ZERO_EN
    ,
    output logic      o_zero
`endif
);

    localparam int DW = CW + 1;
    localparam int PW = 2 * CW + 2;
    localparam int XW = 2 * CW + 3;

    logic signed [DW-1:0] w_dpx;
    logic signed [DW-1:0] w_dpy;
    logic signed [DW-1:0] w_dqx;
    logic signed [DW-1:0] w_dqy;
    logic signed [PW-1:0] r_m_a;
    logic signed [PW-1:0] r_m_b;
    logic signed [XW-1:0] w_c;

    // Unsigned coordinates are zero-extended so every difference is exact.
    assign w_dpx = $signed({1'b0, i_op.p.x}) - $signed({1'b0, i_op.a.x});
    assign w_dpy = $signed({1'b0, i_op.p.y}) - $signed({1'b0, i_op.a.y});
    assign w_dqx = $signed({1'b0, i_op.q.x}) - $signed({1'b0, i_op.b.x});
    assign w_dqy = $signed({1'b0, i_op.q.y}) - $signed({1'b0, i_op.b.y});

    // NOTE: pure datapath registers carry no reset; validity travels in the arbiter's id pipeline.
    always_ff @(posedge clk) begin
        r_m_a <= PW'(w_dpx) * PW'(w_dqy);
        r_m_b <= PW'(w_dpy) * PW'(w_dqx);
    end

    assign w_c = XW'(r_m_a) - XW'(r_m_b);

    always_ff @(posedge clk) begin
        if (!i_reset) begin
            o_pos  <= 1'b0;
`ifdef CROSS_ZERO_EN
            o_zero <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state always uses non-blocking assignment.
            o_pos  <= !w_c[XW-1] && (w_c != '0);
`ifdef CROSS_ZERO_EN
            o_zero <= (w_c == '0);
`endif
        end
    end

endmodule

// File: rtl/cross_arbiter.sv
// Round-robin arbiter with burst lock sharing one cross_core among N_REQ clients.
// Define CROSS_ZERO_EN to add the rsp_zero (collinear) response output.
module cross_arbiter #(
    parameter int N_REQ = 4,
    parameter int CW    = 10,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      lock,
    input  logic [N_REQ*8*CW-1:0] opnd,
    output logic [N_REQ-1:0]      gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_pos
`ifdef CROSS_ZERO_EN
    ,
    output logic                  rsp_zero
`endif
);

    import geofence_pkg::cross_op_t;

    localparam int             OPW     = 8 * CW;
    localparam logic [IDW:0]   LP_NREQ = (IDW + 1)'(N_REQ);
    localparam logic [IDW-1:0] LP_LAST = IDW'(N_REQ - 1);

    logic [OPW-1:0] w_opnd [N_REQ];
    logic           w_any;
    logic [IDW-1:0] w_idx;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] r_rr;
    logic [IDW-1:0] r_owner;
    logic           r_own_vld;
    logic           r_gnt_vld;
    logic [IDW-1:0] r_gnt_id;
    logic           r_s0_vld;
    logic [IDW-1:0] r_s0_id;
    logic           r_s1_vld;
    logic [IDW-1:0] r_s1_id;
    cross_op_t      r_s0_op;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_opnd[i] = opnd[i*OPW +: OPW];
        end
    end

    // Search runs from the farthest offset down so the one closest to rr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch can be inferred.
        w_any = |req;
        w_idx = '0;
        w_sum = '0;
        if (r_own_vld && req[r_owner]) begin
            w_idx = r_owner;
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_sum = {1'b0, r_rr} + (IDW + 1)'(k);
                if (w_sum >= LP_NREQ) begin
                    w_sum = w_sum - LP_NREQ;
                end
                if (req[w_sum[IDW-1:0]]) begin
                    w_idx = w_sum[IDW-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt       <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= '0;
            r_rr      <= '0;
            r_owner   <= '0;
            r_own_vld <= 1'b0;
            r_s0_vld  <= 1'b0;
            r_s0_id   <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_id   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            gnt       <= w_any ? (N_REQ'(1) << w_idx) : '0;
            r_gnt_vld <= w_any;
            r_gnt_id  <= w_idx;
            // An idle cycle means the owner dropped req, which releases the lock.
            r_own_vld <= w_any && lock[w_idx];
            if (w_any) begin
                r_owner <= w_idx;
                r_rr    <= (w_idx == LP_LAST) ? '0 : w_idx + 1'b1;
            end
            r_s0_vld  <= r_gnt_vld;
            r_s0_id   <= r_gnt_id;
            r_s1_vld  <= r_s0_vld;
            r_s1_id   <= r_s0_id;
            rsp_valid <= r_s1_vld;
            rsp_id    <= r_s1_id;
        end
    end

    // The granted client holds its operands through the gnt cycle; S0 samples them at its end.
    always_ff @(posedge clk) begin
        r_s0_op <= cross_op_t'(w_opnd[r_gnt_id]);
    end

    cross_core u_core (
        .clk     (clk),
        .i_reset (reset),
        .i_op    (r_s0_op),
        .o_pos   (rsp_pos)
`ifdef CROSS_ZERO_EN
        ,
        .o_zero  (rsp_zero)
`endif
    );

endmodule

// File: tb/tb_cross_arbiter.sv
// Self-checking bench for cross_arbiter: directed steps plus random traffic
// against a behavioural model (grant rules, cross product, 3-cycle latency).
module tb_cross_arbiter;

    localparam int N   = 4;
    localparam int CW  = 10;
    localparam int IDW = 2;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      lock = '0;
    logic [N*8*CW-1:0] opnd = '0;
    logic [N-1:0]      gnt;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_pos;
`ifdef CROSS_ZERO_EN
    logic              rsp_zero;
`endif

    cross_arbiter #(.N_REQ(N), .CW(CW), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .opnd      (opnd),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_pos   (rsp_pos)
`ifdef CROSS_ZERO_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int id;
        bit pos;
        bit zero;
    } rsp_t;

    // Operand fields per client: Px, Py, Qx, Qy, Ax, Ay, Bx, By.
    int   op [N][8];
    rsp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_rr = 0;
    int   m_own = 0;
    bit   m_own_vld = 1'b0;
    int   m_cur = -1;
    int   last_cap = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++)
            for (int f = 0; f < 8; f++)
                opnd[i*8*CW + (7-f)*CW +: CW] = CW'(op[i][f]);
    endtask

    task automatic rand_op(input int i);
        for (int f = 0; f < 8; f++)
            op[i][f] = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 1023 : 0)
                                           : int'($urandom_range(0, 1023));
        if ($urandom % 6 == 0) begin
            op[i][2] = op[i][0]; op[i][3] = op[i][1];
            op[i][6] = op[i][4]; op[i][7] = op[i][5];
        end
        pack();
    endtask

    // Grant rule: live owner first, else first requester at rr, rr+1, ... mod N.
    function automatic int model_arb();
        if (m_own_vld && req[m_own] == 1'b1) return m_own;
        for (int k = 0; k < N; k++)
            if (req[(m_rr + k) % N] == 1'b1) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic rsp_t model_cross(input int i, input int due);
        rsp_t   r;
        longint c;
        c = longint'(op[i][0] - op[i][4]) * longint'(op[i][3] - op[i][7])
          - longint'(op[i][1] - op[i][5]) * longint'(op[i][2] - op[i][6]);
        r.due  = due;
        r.id   = i;
        r.pos  = (c > 0);
        r.zero = (c == 0);
        return r;
    endfunction

    // Advance one clock: update the model from pre-edge inputs, then check outputs.
    task automatic tick();
        int g;
        bit in_reset;
        bit exp_v;
        in_reset = !reset;
        g = in_reset ? -1 : model_arb();
        last_cap = m_cur;
        if (!in_reset && m_cur >= 0) exp_q.push_back(model_cross(m_cur, cyc + LAT));
        if (in_reset) begin
            exp_q.delete();
            m_rr = 0; m_own_vld = 1'b0; m_cur = -1;
        end else begin
            if (g >= 0) begin
                m_rr = (g + 1) % N;
                m_own_vld = lock[g];
                m_own = g;
            end else begin
                m_own_vld = 1'b0;
            end
            m_cur = g;
        end
        @(posedge clk);
        cyc++;
        #1;
        check("gnt", 32'(gnt), (m_cur >= 0) ? (32'd1 << m_cur) : 32'd0);
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
            check("rsp_pos", 32'(rsp_pos), 32'(exp_q[0].pos));
`ifdef CROSS_ZERO_EN
            check("rsp_zero", 32'(rsp_zero), 32'(exp_q[0].zero));
`endif
            void'(exp_q.pop_front());
        end
        if (in_reset) begin
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
            check("rst_rsp_pos", 32'(rsp_pos), 32'd0);
`ifdef CROSS_ZERO_EN
            check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
`endif
        end
    endtask

    task automatic refresh();
        if (last_cap >= 0) rand_op(last_cap);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // One op from client i: request, drop req on seeing gnt, drain the response.
    task automatic single(input int i, input int px, input int py, input int qx, input int qy,
                          input int ax, input int ay, input int bx, input int by);
        int n;
        op[i][0] = px; op[i][1] = py; op[i][2] = qx; op[i][3] = qy;
        op[i][4] = ax; op[i][5] = ay; op[i][6] = bx; op[i][7] = by;
        pack();
        req = N'(1) << i;
        n = 0;
        tick();
        while (m_cur != i && n < 8) begin
            tick();
            n++;
        end
        check("single_granted_id", 32'(m_cur), 32'(i));
        req = '0;
        idle(LAT + 2);
    endtask

    initial begin
        for (int i = 0; i < N; i++) rand_op(i);
        idle(2);
        reset = 1'b1;

        single(1, 10, 0, 0, 10, 0, 0, 0, 0);
        single(1, 0, 10, 10, 0, 0, 0, 0, 0);
        single(2, 5, 5, 10, 10, 0, 0, 0, 0);
        single(3, 1023, 0, 0, 1023, 0, 1023, 1023, 0);
        single(0, 1023, 0, 0, 1023, 0, 0, 0, 0);
        single(0, 0, 1023, 1023, 0, 0, 0, 0, 0);
        single(3, 0, 0, 0, 0, 1023, 1023, 1023, 1023);

        // All clients requesting without lock, starting from rr = 0.
        reset = 1'b0; tick(); reset = 1'b1;
        req = '1;
        for (int k = 0; k < 8; k++) begin tick(); refresh(); end
        req = '0;
        idle(LAT + 2);

        // Burst lock for client 2, released while it still requests.
        req = 4'b0101; lock = 4'b0100;
        for (int k = 0; k < 5; k++) begin tick(); refresh(); end
        lock = '0;
        for (int k = 0; k < 3; k++) begin tick(); refresh(); end
        // Owner drops req: lock released and round-robin resumes the same cycle.
        lock = 4'b0100;
        for (int k = 0; k < 3; k++) begin tick(); refresh(); end
        req = 4'b0001;
        for (int k = 0; k < 2; k++) begin tick(); refresh(); end
        // Lock without req is ignored.
        req = 4'b0010; lock = 4'b1101;
        for (int k = 0; k < 3; k++) begin tick(); refresh(); end
        req = '0; lock = '0;
        idle(LAT + 2);

        // Reset after the second of three back-to-back grants.
        req = 4'b1110;
        tick(); refresh();
        tick(); refresh();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick(); refresh();
        req = '0;
        idle(LAT + 3);

        // Random traffic: clients hold req until granted, may chain ops.
        for (int c = 0; c < 400; c++) begin
            tick();
            refresh();
            for (int i = 0; i < N; i++) begin
                if (req[i] && m_cur == i && ($urandom % 2 == 1)) req[i] = 1'b0;
                else if (!req[i] && ($urandom % 4 == 0)) req[i] = 1'b1;
            end
            lock = N'($urandom & $urandom);
            if (c % 97 == 50) reset = 1'b0;
            else reset = 1'b1;
        end
        reset = 1'b1;
        req = '0; lock = '0;
        idle(LAT + 3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
